// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter for the data memory with burst locking.
// Optional DMEM_ARB_STATS_EN adds saturating conflict / port-1 grant counters.
module dmem_arbiter #(
   parameter int ADDR_W   = 6,
   parameter int MAX_LOCK = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic              p0_lock,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [31:0]       p0_wdata,
   input  logic [2:0]        p0_bsel,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [31:0]       p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic              p1_lock,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [31:0]       p1_wdata,
   input  logic [2:0]        p1_bsel,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [31:0]       p1_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [2:0]        mem_bsel,
   input  logic [31:0]       mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]       stat_conflicts,
   output logic [15:0]       stat_p1_grants
`endif
);
   localparam int CW = $clog2(MAX_LOCK + 1);
   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
   state_t          r_state;
   logic            r_rr_last;
   logic [CW-1:0]   r_beat;
   logic            r_rv0, r_rv1;
   logic [31:0]     r_rdata0, r_rdata1;
   logic            w_own0, w_own1, w_g0, w_g1, w_keep, w_new_lock;
   logic [CW-1:0]   w_beat_nx;
   // The lock owner keeps the bus only while it still requests; otherwise normal arbitration applies this cycle.
   assign w_own0     = (r_state == LOCK0) && p0_req;
   assign w_own1     = (r_state == LOCK1) && p1_req;
   assign w_g0       = ~rst & (w_own0 | (~w_own1 & p0_req & (~p1_req | r_rr_last)));
   assign w_g1       = ~rst & (w_own1 | (~w_own0 & p1_req & (~p0_req | ~r_rr_last)));
   assign w_beat_nx  = r_beat + CW'(1);
   assign w_keep     = ((w_own0 & p0_lock) | (w_own1 & p1_lock)) && (w_beat_nx != CW'(MAX_LOCK));
   assign w_new_lock = (w_g0 & p0_lock) | (w_g1 & p1_lock);
   assign p0_gnt     = w_g0;
   assign p1_gnt     = w_g1;
   assign mem_read   = (w_g0 & ~p0_we) | (w_g1 & ~p1_we);
   assign mem_write  = (w_g0 & p0_we) | (w_g1 & p1_we);
   assign mem_addr   = w_g0 ? p0_addr  : w_g1 ? p1_addr  : '0;
   assign mem_wdata  = w_g0 ? p0_wdata : w_g1 ? p1_wdata : '0;
   assign mem_bsel   = w_g0 ? p0_bsel  : w_g1 ? p1_bsel  : '0;
   assign p0_rvalid  = r_rv0;
   assign p1_rvalid  = r_rv1;
   assign p0_rdata   = r_rdata0;
   assign p1_rdata   = r_rdata1;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_rr_last <= 1'b1;
         r_beat    <= '0;
      end else if (w_own0 | w_own1) begin
         r_rr_last <= w_own1;
         r_state   <= w_keep ? r_state : IDLE;
         r_beat    <= w_keep ? w_beat_nx : '0;
      end else begin
         if (w_g0 | w_g1) r_rr_last <= w_g1;
         r_state <= w_new_lock ? (w_g1 ? LOCK1 : LOCK0) : IDLE;
         r_beat  <= w_new_lock ? CW'(1) : '0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rv0    <= 1'b0;
         r_rv1    <= 1'b0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         r_rv0 <= w_g0 & ~p0_we;
         r_rv1 <= w_g1 & ~p1_we;
         if (w_g0 & ~p0_we) r_rdata0 <= mem_rdata;
         if (w_g1 & ~p1_we) r_rdata1 <= mem_rdata;
      end
   end
`ifdef DMEM_ARB_STATS_EN
   logic [15:0] r_conf, r_p1g;
   logic [1:0]  w_stall;
   logic [16:0] w_conf_sum;
   assign w_stall        = {1'b0, p0_req & ~w_g0} + {1'b0, p1_req & ~w_g1};
   assign w_conf_sum     = {1'b0, r_conf} + {15'b0, w_stall};
   assign stat_conflicts = r_conf;
   assign stat_p1_grants = r_p1g;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_conf <= '0;
         r_p1g  <= '0;
      end else begin
         r_conf <= w_conf_sum[16] ? 16'hFFFF : w_conf_sum[15:0];
         r_p1g  <= (w_g1 && r_p1g != 16'hFFFF) ? r_p1g + 16'd1 : r_p1g;
      end
   end
`endif
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory (64 x 32-bit words, byte/half/word access via 3-bit funct3-style byte_select) between two requesters: port 0 (core load/store unit) and port 1 (DMA/debug loader).
- Round-robin arbitration with optional bus locking for multi-beat bursts and a lock-length starvation guard.
- Read data is registered, giving one-cycle read latency.
- Sits between the requesters and the data memory. It is the only driver of the memory's MemRead/MemWrite/addr/data_in/byte_select.

Parameters:
ADDR_W, 6, word address width (64 words)
MAX_LOCK, 8, maximum consecutive granted beats under lock before forced release (>=2)

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  synchronous active-high reset
p0_req  input  1  port 0 access request
p0_we  input  1  port 0 write (1) / read (0)
p0_lock  input  1  port 0 requests to keep ownership after this beat
p0_addr  input  ADDR_W  port 0 word address
p0_wdata  input  32  port 0 store data
p0_bsel  input  3  port 0 byte select (000 B, 001 H, 010 W, 100 BU, 101 HU)
p0_gnt  output  1  port 0 request accepted this cycle
p0_rvalid  output  1  port 0 read data valid
p0_rdata  output  32  port 0 read data
p1_req, p1_we, p1_lock, p1_addr, p1_wdata, p1_bsel, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1
mem_read  output  1  to memory MemRead
mem_write  output  1  to memory MemWrite
mem_addr  output  ADDR_W  to memory addr
mem_wdata  output  32  to memory data_in
mem_bsel  output  3  to memory byte_select
mem_rdata  input  32  from memory data_out (combinational, already extended)

Behaviour:
- Grant is combinational in the cycle of request. Granted port's addr/wdata/bsel are muxed to mem_*.
- mem_read = gnt & ~we; mem_write = gnt & we. Both are 0 with no grant; mem_addr/mem_wdata/mem_bsel are then 0.
- At most one gnt per cycle. A non-granted requester holds req and its fields stable until gnt.
- Arbitration, unlocked: only one req → grant it. Both req → grant the port not granted last (rr_last pointer). rr_last updates on every grant.
- FSM states: IDLE, LOCK0, LOCK1.
  - IDLE→LOCKn when port n is granted with pn_lock=1.
  - In LOCKn, port n has exclusive grant whenever pn_req=1; the other port is never granted.
  - LOCKn→IDLE when pn_req=0, pn_lock=0 on a granted beat, or the beat counter reaches MAX_LOCK.
- Beat counter: resets to 1 on the IDLE→LOCK grant and increments per granted beat in LOCKn.
  - The beat that makes count == MAX_LOCK is granted. The FSM then returns to IDLE with rr_last = n, so the other port wins the next tie.
- Read pipeline: on a granted read, mem_rdata is captured into pn_rdata at the next posedge; pn_rvalid = 1 for exactly the following cycle.
  - Writes produce no rvalid. pn_rdata holds its value when rvalid=0.
- Back-to-back reads from the same port give rvalid every cycle. Read-after-write to the same address on consecutive cycles returns the new data (write lands at posedge before the read cycle).
- Reset (sync, any cycle including mid-lock): FSM=IDLE, rr_last=1 (port 0 wins first tie), beat counter=0, all gnt/rvalid/mem_read/mem_write=0, pn_rdata=0.
  - A read granted in the reset cycle yields no rvalid.
- Simultaneous: lock-owner drops req while the other requests → other is granted in that same cycle (FSM exit is evaluated combinationally for grant).

Optional Feature:
DMEM_ARB_STATS_EN
- Defined: adds outputs stat_conflicts[15:0] and stat_p1_grants[15:0], both reset to 0.
  - stat_conflicts counts cycles with a req held but not granted (either port, +1 per stalled port).
  - stat_p1_grants counts port 1 grants.
  - Both saturate at 16'hFFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then p0 read addr 0 alone → p0_gnt=1 same cycle, next cycle p0_rvalid=1, p0_rdata=17.
- p0 and p1 both reading (addr 1, addr 2) for 4 cycles → grants alternate p0,p1,p0,p1; rdata 9 and 25 delivered one cycle after each grant.
- p1 SW 32'hDEADBEEF to addr 5, then p0 LBU addr 5 next cycle → p0_rdata=32'h000000EF; LB → 32'hFFFFFFEF.
- p1 lock burst with p0 requesting continuously, MAX_LOCK=8 → p1 granted 8 consecutive beats, p0 granted on the 9th cycle; p0 stalled 8 cycles (stat_conflicts=8 with DMEM_ARB_STATS_EN).
- Assert rst during LOCK0 with a read granted → no rvalid next cycle, FSM IDLE, subsequent tie grants p0.
- p0 locked, drops req while p1 requests → p1_gnt=1 that same cycle, FSM IDLE.
